mult_table_writer: RTL and testbench

- Generates the complete N×N-bit multiplication lookup table and writes it, one entry per write, into a writable table memory.
- It is the write-side counterpart of the table lookup memory: entry {a, b} holds a*b.
- Each product is computed with an N-cycle sequential shift-add multiplier.
- It sits between the control sequencer (start/abort/done) and the write port of the table RAM, so tables are built in-system rather than loaded from a data file.

---
 rtl/mult_table_writer_if.sv | 24 ++
 rtl/mult_table_writer.sv | 126 ++++++++++++
 tb/tb_mult_table_writer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_table_writer_if.sv
// Write port between the table generator and the table RAM.
// The generator drives address/data/enable and the RAM returns wr_ready.
interface mult_table_writer_if #(
  parameter int N = 4
) ();
  logic             wr_en;
  logic [2*N-1:0]   wr_addr;
  logic [2*N-1:0]   wr_data;
  logic             wr_ready;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/mult_table_writer.sv
// Builds the full NxN multiplication table in-system: every {a,b} entry gets a*b,
// computed with an N-cycle shift-add multiplier and written in ascending address order.
module mult_table_writer #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  mult_table_writer_if.master wr
);

  localparam int AW = 2 * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    WRITE,
    DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   addr;      // {a, b}; b wraps into a as one counter
  logic [AW-1:0]   mcand;
  logic [AW-1:0]   acc;
  logic [N-1:0]    mplier;
  logic [CW-1:0]   cnt;
  logic            wr_en_q;

  // acc is frozen while in WRITE, so it doubles as the write data register.
  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = addr;
  assign wr.wr_data = acc;

  // NOTE: every register here uses non-blocking assignment so all updates in a
  // cycle see the pre-edge values (e.g. acc adds the old mcand, not the shifted one).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      wr_en_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            mcand  <= AW'(addr[AW-1:N]);
            mplier <= addr[N-1:0];
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end

        MUL: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
              wr_en_q <= 1'b1;
              state   <= WRITE;
            end
          end
        end

        WRITE: begin
          // abort wins over wr_ready; a write accepted on this edge still lands in the RAM.
          if (abort) begin
            wr_en_q <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (wr.wr_ready) begin
            wr_en_q <= 1'b0;
            if (&addr) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr  <= addr + AW'(1);
              state <= LOAD;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          wr_en_q <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_table_writer.sv
// Self-checking bench for mult_table_writer: N=4 and N=2 instances, a table-RAM model,
// a scoreboard of products/addresses/timing, random backpressure and random aborts.
module tb_mult_table_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_s [2];
  logic abort_s [2];
  logic ready_s [2];
  logic busy4, done4, busy2, done2;

  mult_table_writer_if #(.N(4)) wr4 ();
  mult_table_writer_if #(.N(2)) wr2 ();

  assign wr4.wr_ready = ready_s[0];
  assign wr2.wr_ready = ready_s[1];

  mult_table_writer #(.N(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_s[0]),
    .abort (abort_s[0]),
    .busy  (busy4),
    .done  (done4),
    .wr    (wr4.master)
  );

  mult_table_writer #(.N(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_s[1]),
    .abort (abort_s[1]),
    .busy  (busy2),
    .done  (done2),
    .wr    (wr2.master)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // Reference model state, one slot per instance (0: N=4, 1: N=2).
  int s_edge    [2];
  int last_acc  [2];
  int exp_addr  [2];
  int wcount    [2];
  int done_cnt  [2];
  int done_rel  [2];
  int last_addr [2];
  bit prev_en   [2];
  bit prev_acc  [2];
  bit active    [2];
  int prev_addr [2];
  int prev_data [2];
  int mem [2][256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arms the model for a sweep whose start is sampled on the next edge.
  task automatic arm(input int i);
    s_edge[i]   = edge_cnt + 1;
    last_acc[i] = 0;
    exp_addr[i] = 0;
    wcount[i]   = 0;
    done_cnt[i] = 0;
    done_rel[i] = -1;
    last_addr[i] = -1;
    active[i]   = 1'b1;
    prev_en[i]  = 1'b0;
    prev_acc[i] = 1'b0;
    start_s[i]  = 1'b1;
  endtask

  // Cycle k of a sweep is the value seen just before the k-th edge after the start edge.
  task automatic mon_step(input int i, input int n, input logic en, input logic rdy,
                          input int addr, input int data, input logic bsy, input logic dn);
    int rel;
    rel = edge_cnt - s_edge[i] + 1;
    if (en) begin
      if (!prev_en[i] || prev_acc[i]) begin
        check($sformatf("wr_cycle_n%0d", n), rel, last_acc[i] + n + 2);
        check($sformatf("wr_addr_n%0d", n), addr, exp_addr[i]);
      end else begin
        check($sformatf("stall_addr_n%0d", n), addr, prev_addr[i]);
        check($sformatf("stall_data_n%0d", n), data, prev_data[i]);
      end
      if (rdy) begin
        check($sformatf("product_n%0d", n), data, (addr >> n) * (addr % (1 << n)));
        mem[i][addr] = data;
        last_addr[i] = addr;
        exp_addr[i]++;
        wcount[i]++;
        last_acc[i] = rel;
      end
    end
    if (dn) begin
      check($sformatf("done_expected_n%0d", n), active[i], 1);
      check($sformatf("done_cycle_n%0d", n), rel, last_acc[i] + 1);
      check($sformatf("done_writes_n%0d", n), wcount[i], 1 << (2 * n));
      check($sformatf("done_busy_n%0d", n), bsy, 0);
      done_cnt[i]++;
      done_rel[i] = rel;
      active[i] = 1'b0;
    end
    prev_en[i]   = en;
    prev_acc[i]  = en && rdy;
    prev_addr[i] = addr;
    prev_data[i] = data;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(0, 4, wr4.wr_en, wr4.wr_ready, int'(wr4.wr_addr), int'(wr4.wr_data), busy4, done4);
      mon_step(1, 2, wr2.wr_en, wr2.wr_ready, int'(wr2.wr_addr), int'(wr2.wr_data), busy2, done2);
    end
  end

  task automatic wait_done(input int i, input int budget);
    int k;
    k = 0;
    while (done_cnt[i] == 0 && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("done_seen_%0d", i), done_cnt[i], 1);
  endtask

  initial begin
    int k, c, stall12, pres12;
    bit found;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      ready_s[i] = 1'b1;
      active[i]  = 1'b0;
      wcount[i]  = 0;
      done_cnt[i] = 0;
    end

    // Reset state, then idle without start.
    #12;
    check("rst_wr_en", wr4.wr_en, 0);
    check("rst_addr", wr4.wr_addr, 0);
    check("rst_data", wr4.wr_data, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    #10 rst_n = 1'b1;
    mon_en = 1'b1;
    tick();
    for (int j = 0; j < 6; j++) begin
      check("idle_wr_en4", wr4.wr_en, 0);
      check("idle_wr_en2", wr2.wr_en, 0);
      tick();
    end

    // Sweep A: both widths, no backpressure, exact timing and table contents.
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) mem[i][a] = -1;
    arm(0);
    arm(1);
    tick();
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    check("busy_cycle1", busy4, 1);
    wait_done(1, 200);
    wait_done(0, 2000);
    check("done_rel_n4", done_rel[0], 1537);
    check("done_rel_n2", done_rel[1], 65);
    check("spot_00", mem[0][8'h00], 0);
    check("spot_37", mem[0][8'h37], 21);
    check("spot_F1", mem[0][8'hF1], 15);
    check("spot_FF", mem[0][8'hFF], 225);
    check("spot2_F", mem[1][4'hF], 9);
    check("spot2_6", mem[1][4'h6], 2);
    check("idle_after_done", busy4, 0);

    // Sweep B: random backpressure, plus a directed 3-cycle stall at 0x12.
    arm(0);
    arm(1);
    tick();
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    stall12 = 0;
    pres12  = 0;
    k = 0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && k < 20000) begin
      if (wr4.wr_en && wr4.wr_addr == 8'h12) begin
        pres12++;
        ready_s[0] = (stall12 >= 3);
        if (stall12 < 3) stall12++;
      end else begin
        ready_s[0] = ($urandom_range(0, 3) != 0);
      end
      ready_s[1] = ($urandom_range(0, 2) != 0);
      tick();
      k++;
    end
    ready_s[0] = 1'b1;
    ready_s[1] = 1'b1;
    check("stall12_cycles", pres12, 4);
    check("stallB_done4", done_cnt[0], 1);
    check("stallB_done2", done_cnt[1], 1);
    tick();

    // Abort in MUL while computing 0x45; start while busy must be ignored.
    arm(0);
    tick();
    start_s[0] = 1'b0;
    repeat (100) tick();
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    check("busy_ignore_start", busy4, 1);
    found = 1'b0;
    k = 0;
    while (!found && k < 1000) begin
      if (wr4.wr_addr == 8'h45 && !wr4.wr_en) found = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    check("reach_45", found, 1);
    tick();
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    active[0] = 1'b0;
    check("abort_busy", busy4, 0);
    check("abort_wr_en", wr4.wr_en, 0);
    check("abort_writes", wcount[0], 8'h45);
    for (int j = 0; j < 12; j++) begin
      check("post_abort_wr_en", wr4.wr_en, 0);
      tick();
    end
    check("abort_no_done", done_cnt[0], 0);

    // Restart after abort: first write goes to 0x00.
    arm(0);
    tick();
    start_s[0] = 1'b0;
    k = 0;
    while (wcount[0] == 0 && k < 50) begin
      tick();
      k++;
    end
    check("restart_count", wcount[0], 1);
    check("restart_addr", last_addr[0], 0);
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    active[0] = 1'b0;
    check("abort2_busy", busy4, 0);

    // Random abort points on the N=2 instance.
    for (int r = 0; r < 4; r++) begin
      c = $urandom_range(1, 63);
      arm(1);
      tick();
      start_s[1] = 1'b0;
      repeat (c - 1) tick();
      abort_s[1] = 1'b1;
      tick();
      abort_s[1] = 1'b0;
      active[1] = 1'b0;
      check($sformatf("rand_abort_writes_c%0d", c), wcount[1], c / 4);
      check("rand_abort_busy", busy2, 0);
      repeat (8) tick();
      check("rand_abort_no_done", done_cnt[1], 0);
      check("rand_abort_wr_en", wr2.wr_en, 0);
    end

    // Asynchronous reset in the middle of MUL for entry 0x23.
    arm(0);
    tick();
    start_s[0] = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 400) begin
      if (wr4.wr_addr == 8'h23 && !wr4.wr_en) found = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    check("reach_23", found, 1);
    tick();
    tick();
    check("pre_rst_busy", busy4, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", wr4.wr_en, 0);
    check("async_rst_addr", wr4.wr_addr, 0);
    check("async_rst_data", wr4.wr_data, 0);
    check("async_rst_busy", busy4, 0);
    check("async_rst_done", done4, 0);
    check("async_rst_addr2", wr2.wr_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int j = 0; j < 10; j++) begin
      check("post_rst_wr_en", wr4.wr_en, 0);
      check("post_rst_busy", busy4, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
